// File: rtl/arb_burst_mux.sv
// Four-client burst multiplexer in front of an external round-robin arbiter.
// The granted client's beats go through one output register; the grant is released on a natural or forced burst end.
module arb_burst_mux #(
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 16
) (
    input  logic                clock,
    input  logic                aresetn,
    input  logic [3:0]          s_valid,
    input  logic [4*DATA_W-1:0] s_data,
    input  logic [3:0]          s_last,
    output logic [3:0]          s_ready,
    output logic [3:0]          request,
    input  logic [3:0]          grant,
    output logic [3:0]          done,
    output logic                m_valid,
    output logic [DATA_W-1:0]   m_data,
    output logic                m_last,
    input  logic                m_ready,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

    localparam logic [8:0] LAST_CNT = 9'(MAX_BEATS - 1);

    state_t            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [8:0]        cnt_q, cnt_d;
    logic [3:0]        gap_q, gap_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;

    logic [3:0]        owner_oh;
    logic [1:0]        grant_idx;
    logic              owner_granted;
    logic              out_free;
    logic [DATA_W-1:0] owner_data;

    assign owner_oh      = 4'b0001 << owner_q;
    assign owner_granted = |(grant & owner_oh);
    assign out_free      = m_ready || !m_valid_q;
    assign owner_data    = s_data[owner_q*DATA_W +: DATA_W];

    always_comb begin
        grant_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (grant[i]) grant_idx = 2'(i);
        end
    end

    // The released client is kept off the arbiter for the release cycle and the one after it.
    always_comb begin
        request = '0;
        if (aresetn) begin
            request = s_valid & ~gap_q & ((state_q == RELEASE) ? ~owner_oh : 4'b1111);
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gap_d     = 4'b0000;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        err_d     = err_q;
        s_ready   = 4'b0000;
        done      = 4'b0000;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (grant != 4'b0000) begin
                    if ($onehot(grant) && |(grant & request)) begin
                        state_d = XFER;
                        owner_d = grant_idx;
                        cnt_d   = 9'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            XFER: begin
                // Losing the grant mid-burst abandons the burst; the registered beat still drains.
                if (!owner_granted) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    s_ready = out_free ? owner_oh : 4'b0000;
                    if (out_free && s_valid[owner_q]) begin
                        m_valid_d = 1'b1;
                        m_data_d  = owner_data;
                        m_last_d  = s_last[owner_q] || (cnt_q == LAST_CNT);
                        cnt_d     = cnt_q + 9'd1;
                        if (m_last_d) state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                done    = owner_oh;
                gap_d   = owner_oh;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            owner_q   <= 2'd0;
            cnt_q     <= 9'd0;
            gap_q     <= 4'b0000;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            err_q     <= err_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_last  = m_last_q;
    assign err     = err_q;

endmodule

// File: tb/tb_arb_burst_mux.sv
// Bench for arb_burst_mux: acts as the round-robin arbiter and the client sources.
// A burst-level model predicts the merged stream, done pulses, request gaps and s_ready.
module tb_arb_burst_mux;

    localparam int DW = 16;
    localparam int MB = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic            clock = 1'b0;
    logic            aresetn;
    logic [3:0]      s_valid, s_last, s_ready, request, grant, done;
    logic [4*DW-1:0] s_data;
    logic            m_valid, m_last, m_ready, err;
    logic [DW-1:0]   m_data;

    int checks = 0;
    int errors = 0;

    beat_t srcQ[4][$];
    beat_t refQ[4][$];
    beat_t expQ[$];

    always #5 clock = ~clock;

    arb_burst_mux #(.DATA_W(DW), .MAX_BEATS(MB)) dut (
        .clock   (clock),
        .aresetn (aresetn),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_last  (s_last),
        .s_ready (s_ready),
        .request (request),
        .grant   (grant),
        .done    (done),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready),
        .err     (err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pendingWork(input int busy);
        int n;
        n = expQ.size() + busy;
        for (int c = 0; c < 4; c++) n += srcQ[c].size();
        return n;
    endfunction

    task automatic genTraffic(input int nBursts);
        beat_t b;
        int    c;
        int    len;
        for (int i = 0; i < 4; i++) begin
            srcQ[i].delete();
            refQ[i].delete();
        end
        expQ.delete();
        for (int n = 0; n < nBursts; n++) begin
            c   = (n == 0) ? 1 : $urandom_range(0, 3);
            len = (n == 0) ? 6 : $urandom_range(1, 7);
            for (int k = 0; k < len; k++) begin
                b.data = DW'($urandom);
                b.last = (k == len - 1);
                srcQ[c].push_back(b);
                refQ[c].push_back(b);
            end
        end
    endtask

    task automatic resetPulse();
        @(negedge clock);
        aresetn = 1'b0;
        grant   = 4'b0000;
        s_valid = 4'b0000;
        #1;
        checkOutput("resetErrClear", err, 0);
        @(negedge clock);
        aresetn = 1'b1;
    endtask

    // Randomised traffic; the bench grants round-robin and holds the grant until the done pulse.
    task automatic applyStimulus(input int nBursts);
        int         busy, xferExp, startPending, doneNext;
        int         owner, burstLen, accCnt, rrPtr, stallRun, cyc, cc;
        int         blk[4];
        logic [3:0] prevDone, expReq, expRdy, expDone, ownerOh;
        logic       prevStall;
        beat_t      e;

        busy = 0; xferExp = 0; startPending = 0; doneNext = 0;
        owner = 0; burstLen = 0; accCnt = 0; rrPtr = 0; stallRun = 0; cyc = 0;
        prevDone = 4'b0000; prevStall = 1'b0;
        for (int c = 0; c < 4; c++) blk[c] = 0;
        genTraffic(nBursts);

        while (pendingWork(busy) != 0 && cyc < 4000) begin
            @(negedge clock);
            cyc++;
            for (int c = 0; c < 4; c++) if (blk[c] > 0) blk[c]--;
            if (startPending != 0) begin
                xferExp      = 1;
                startPending = 0;
            end

            if (busy == 0) begin
                grant = 4'b0000;
                for (int k = 0; k < 4; k++) begin
                    cc = (rrPtr + k) % 4;
                    if (busy == 0 && srcQ[cc].size() > 0 && refQ[cc].size() > 0 && blk[cc] == 0) begin
                        busy         = 1;
                        owner        = cc;
                        rrPtr        = (cc + 1) % 4;
                        burstLen     = 0;
                        accCnt       = 0;
                        startPending = 1;
                        grant        = 4'b0001 << cc;
                        do begin
                            e = refQ[cc].pop_front();
                            burstLen++;
                            e.last = e.last || (burstLen == MB);
                            expQ.push_back(e);
                        end while (!e.last && refQ[cc].size() > 0);
                    end
                end
            end else begin
                grant = 4'b0001 << owner;
            end

            s_data = '0;
            s_last = 4'b0000;
            for (int c = 0; c < 4; c++) begin
                s_valid[c] = (srcQ[c].size() > 0);
                if (srcQ[c].size() > 0) begin
                    s_data[c*DW +: DW] = srcQ[c][0].data;
                    s_last[c]          = srcQ[c][0].last;
                end
                if (c == owner && xferExp != 0 && $urandom_range(0, 3) == 0) s_valid[c] = 1'b0;
            end

            if (stallRun > 0) begin
                m_ready = 1'b0;
                stallRun--;
            end else if ($urandom_range(0, 19) == 0) begin
                m_ready  = 1'b0;
                stallRun = 4;
            end else begin
                m_ready = ($urandom_range(0, 3) != 0);
            end

            #1;
            ownerOh = 4'b0001 << owner;
            expDone = (doneNext != 0) ? ownerOh : 4'b0000;
            checkOutput("done", done, expDone);
            expReq = s_valid & ~expDone & ~prevDone;
            checkOutput("request", request, expReq);
            prevDone = expDone;
            if (doneNext != 0) begin
                busy       = 0;
                blk[owner] = 2;
                doneNext   = 0;
            end

            expRdy = (xferExp != 0 && (m_ready || !m_valid)) ? ownerOh : 4'b0000;
            checkOutput("sReady", s_ready, expRdy);
            for (int c = 0; c < 4; c++) begin
                if (s_valid[c] && s_ready[c] && srcQ[c].size() > 0) void'(srcQ[c].pop_front());
            end
            if (xferExp != 0 && s_valid[owner] && expRdy[owner]) begin
                accCnt++;
                if (accCnt == burstLen) begin
                    xferExp  = 0;
                    doneNext = 1;
                end
            end

            if (prevStall) checkOutput("holdValid", m_valid, 1);
            if (m_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", m_valid, 0);
                end else begin
                    checkOutput("mData", m_data, expQ[0].data);
                    checkOutput("mLast", m_last, expQ[0].last);
                    if (m_ready) void'(expQ.pop_front());
                end
            end
            prevStall = m_valid && !m_ready;
            checkOutput("errClear", err, 0);
        end

        checkOutput("drainTimeout", pendingWork(busy), 0);
        @(negedge clock);
        grant   = 4'b0000;
        s_valid = 4'b0000;
        m_ready = 1'b1;
    endtask

    initial begin
        aresetn = 1'b0;
        s_valid = 4'b1111;
        s_data  = '0;
        s_last  = 4'b0000;
        grant   = 4'b0000;
        m_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        checkOutput("rstRequest", request, 4'b0000);
        checkOutput("rstReady", s_ready, 4'b0000);
        checkOutput("rstDone", done, 4'b0000);
        checkOutput("rstValid", m_valid, 0);
        checkOutput("rstLast", m_last, 0);
        checkOutput("rstData", m_data, 0);
        checkOutput("rstErr", err, 0);
        s_valid = 4'b0000;
        @(negedge clock);
        aresetn = 1'b1;

        // Multi-bit grant in IDLE is refused and flagged.
        @(negedge clock);
        s_valid = 4'b0110;
        grant   = 4'b0110;
        @(negedge clock);
        grant   = 4'b0000;
        s_valid = 4'b0000;
        #1;
        checkOutput("errMultiGrant", err, 1);
        checkOutput("noReadyMultiGrant", s_ready, 4'b0000);
        @(negedge clock);
        #1;
        checkOutput("noBeatMultiGrant", m_valid, 0);
        checkOutput("errSticky", err, 1);
        resetPulse();

        // Grant to a client that is not requesting.
        @(negedge clock);
        grant = 4'b0001;
        @(negedge clock);
        grant = 4'b0000;
        #1;
        checkOutput("errNoRequest", err, 1);
        resetPulse();

        // Grant withdrawn mid-burst.
        @(negedge clock);
        s_valid          = 4'b0010;
        s_data           = '0;
        s_data[DW +: DW] = 16'hA5A5;
        grant            = 4'b0010;
        m_ready          = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("dropReady", s_ready, 4'b0010);
        @(negedge clock);
        grant = 4'b0000;
        #1;
        checkOutput("dropReadyGone", s_ready, 4'b0000);
        checkOutput("dropNoDone0", done, 4'b0000);
        @(negedge clock);
        #1;
        checkOutput("dropErr", err, 1);
        checkOutput("dropNoDone1", done, 4'b0000);
        checkOutput("dropDrainValid", m_valid, 1);
        checkOutput("dropDrainData", m_data, 16'hA5A5);
        m_ready = 1'b1;
        s_valid = 4'b0000;
        @(negedge clock);
        #1;
        checkOutput("dropDrained", m_valid, 0);
        checkOutput("dropNoDone2", done, 4'b0000);
        resetPulse();

        applyStimulus(24);

        // Asynchronous reset while a beat sits in the output register.
        @(negedge clock);
        s_valid              = 4'b0100;
        s_data               = '0;
        s_data[2*DW +: DW]   = 16'hBEEF;
        s_last               = 4'b0000;
        grant                = 4'b0100;
        m_ready              = 1'b0;
        @(negedge clock);
        #1;
        checkOutput("midReady", s_ready, 4'b0100);
        @(negedge clock);
        #1;
        checkOutput("midValid", m_valid, 1);
        checkOutput("midData", m_data, 16'hBEEF);
        aresetn = 1'b0;
        #1;
        checkOutput("midRstValid", m_valid, 0);
        checkOutput("midRstData", m_data, 0);
        checkOutput("midRstLast", m_last, 0);
        checkOutput("midRstReady", s_ready, 4'b0000);
        checkOutput("midRstRequest", request, 4'b0000);
        checkOutput("midRstDone", done, 4'b0000);
        checkOutput("midRstErr", err, 0);
        @(negedge clock);
        aresetn = 1'b1;
        s_valid = 4'b0000;
        grant   = 4'b0000;
        m_ready = 1'b1;

        applyStimulus(16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_burst_mux.md
ARB_BURST_MUX -- requirements
Module: arb_burst_mux

Interface
REQ-001 Parameter DATA_W, default 32, beat data width in bits.
REQ-002 Parameter MAX_BEATS, default 16, maximum beats per grant before forced release; legal range 1..256.
REQ-003 clock  input  1  single clock; all logic rising-edge.
REQ-004 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-005 s_valid  input  4  per-client beat valid.
REQ-006 s_data  input  4*DATA_W  per-client beat data; client i in bits [i*DATA_W +: DATA_W].
REQ-007 s_last  input  4  per-client end-of-burst marker, qualified by s_valid.
REQ-008 s_ready  output  4  per-client beat accept.
REQ-009 request  output  4  per-client arbitration request to the round robin arbiter.
REQ-010 grant  input  4  one-hot grant from the arbiter.
REQ-011 done  output  4  one-cycle release pulse to the arbiter for the owning client.
REQ-012 m_valid  output  1  merged stream valid.
REQ-013 m_data  output  DATA_W  merged stream data.
REQ-014 m_last  output  1  merged stream end-of-burst (set on natural or forced end).
REQ-015 m_ready  input  1  merged stream accept.
REQ-016 err  output  1  sticky protocol error flag.

Function
REQ-017 FSM states IDLE, XFER, RELEASE; one owner register (2 bits) valid in XFER/RELEASE.
REQ-018 request[i] = s_valid[i] except forced 0 in the RELEASE cycle and the cycle after for the released client.
REQ-019 IDLE -> XFER when grant is exactly one-hot and the granted client has request[i]=1; owner latched, beat counter cleared.
REQ-020 In IDLE, grant with >1 bit set or set on a non-requesting client is ignored and sets err.
REQ-021 s_ready[owner] = XFER and (m_ready or not m_valid); all other s_ready bits 0.
REQ-022 Accepted beat registered into m_data/m_valid next cycle (1-cycle latency); m_valid holds with stable m_data/m_last until m_ready.
REQ-023 Beat counter (9 bits) increments per accepted beat; m_last=1 on beat with s_last=1 or count = MAX_BEATS-1 before increment.
REQ-024 XFER -> RELEASE on acceptance of the m_last beat; RELEASE lasts exactly 1 cycle with done[owner]=1, then IDLE.
REQ-025 Forced release mid-burst: remaining client beats continue as a new burst after re-arbitration, no beat dropped or duplicated.
REQ-026 grant[owner] dropping in XFER: stop accepting, set err, go to IDLE without done pulse; already-registered beat still drains.
REQ-027 done bits other than owner always 0; at most one done bit high in any cycle.
REQ-028 err clears only on reset.
REQ-029 Back-to-back: same client may re-win immediately after the 1-cycle request gap; minimum 3 cycles between last beat accept and next first beat accept.

Reset
REQ-030 aresetn low asynchronously forces: state IDLE, s_ready=0, request=0, done=0, m_valid=0, m_last=0, m_data=0, err=0, counter=0.
REQ-031 Reset mid-burst discards the registered beat; after release, first request reflects s_valid the next edge.

Verification
REQ-032 Client 0 sends 3 beats (last on 3rd), grant=0001 -> 3 beats on m_* in order, m_last on beat 3, done=0001 one cycle, request[0] low 2 cycles.
REQ-033 Clients 0 and 3 request, grant=1000 then 0001 -> client 3 burst fully precedes client 0 burst, no interleaving.
REQ-034 MAX_BEATS=4, client 1 sends 6-beat burst -> m_last on beat 4, done=0010, re-request, beats 5-6 after next grant, m_last on beat 6.
REQ-035 m_ready held 0 for 5 cycles mid-burst -> m_data stable, s_ready[owner]=0, no beat lost; resumes on m_ready=1.
REQ-036 grant=0110 in IDLE -> no transfer, err=1; grant dropped mid-burst -> err=1, no done.
REQ-037 aresetn low mid-burst -> all outputs 0 same cycle, err=0; normal burst completes after release.
